// File: rtl/pp_sequencer.sv
// Program sequencer: walks the step address through the program ROM and registers
// the returned control word toward the datapath, with halt/resume and single-step.
module pp_sequencer #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned END_ADDR = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  input  logic [3:0]        rom_RegAddr,
  input  logic [2:0]        rom_ALUCode,
  input  logic              rom_Reg_CE,
  input  logic              rom_CY_CE,
  input  logic              rom_A_CE,
  input  logic              rom_ResetCY,
  output logic [3:0]        RegAddr,
  output logic [2:0]        ALUCode,
  output logic              Reg_CE,
  output logic              CY_CE,
  output logic              A_CE,
  output logic              ResetCY,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(END_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        regaddr_q, regaddr_d;
  logic [2:0]        alucode_q, alucode_d;
  logic              reg_ce_q, reg_ce_d;
  logic              cy_ce_q, cy_ce_d;
  logic              a_ce_q, a_ce_d;
  logic              resetcy_q, resetcy_d;
  logic              done_q, done_d;
  logic              issue;

  // Halt outranks any issue; without step_mode every RUN cycle issues.
  assign issue = !halt && (!step_mode || step);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    regaddr_d = regaddr_q;
    alucode_d = alucode_q;
    reg_ce_d  = 1'b0;
    cy_ce_d   = 1'b0;
    a_ce_d    = 1'b0;
    resetcy_d = 1'b0;
    done_d    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start && !halt) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_PAUSE;
        end else if (issue) begin
          regaddr_d = rom_RegAddr;
          alucode_d = rom_ALUCode;
          reg_ce_d  = rom_Reg_CE;
          cy_ce_d   = rom_CY_CE;
          a_ce_d    = rom_A_CE;
          resetcy_d = rom_ResetCY;
          if (addr_q == LAST) state_d = S_DONE;
          else                addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_PAUSE: begin
        if (start && !halt) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      regaddr_q <= '0;
      alucode_q <= '0;
      reg_ce_q  <= 1'b0;
      cy_ce_q   <= 1'b0;
      a_ce_q    <= 1'b0;
      resetcy_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      regaddr_q <= regaddr_d;
      alucode_q <= alucode_d;
      reg_ce_q  <= reg_ce_d;
      cy_ce_q   <= cy_ce_d;
      a_ce_q    <= a_ce_d;
      resetcy_q <= resetcy_d;
      done_q    <= done_d;
    end
  end

  assign addr    = addr_q;
  assign RegAddr = regaddr_q;
  assign ALUCode = alucode_q;
  assign Reg_CE  = reg_ce_q;
  assign CY_CE   = cy_ce_q;
  assign A_CE    = a_ce_q;
  assign ResetCY = resetcy_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done    = done_q;

endmodule

// File: tb/tb_pp_sequencer.sv
// Directed bench for pp_sequencer: a 13-step program instance and a single-step
// (END_ADDR=0) instance, each fed by a combinational ROM table.
module tb_pp_sequencer;

  logic       clk;
  logic       rst;
  logic       start, halt, step_mode, step;
  logic       b_start, b_halt, b_step_mode, b_step;
  logic [4:0] a_addr, b_addr;
  logic [3:0] a_rom_ra, b_rom_ra, a_ra, b_ra;
  logic [2:0] a_rom_alu, b_rom_alu, a_alu, b_alu;
  logic       a_rom_rce, a_rom_cce, a_rom_ace, a_rom_rcy;
  logic       b_rom_rce, b_rom_cce, b_rom_ace, b_rom_rcy;
  logic       a_rce, a_cce, a_ace, a_rcy, a_busy, a_done;
  logic       b_rce, b_cce, b_ace, b_rcy, b_busy, b_done;
  logic [10:0] a_ctrl, b_ctrl;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  int en0;

  // {RegAddr[3:0], ALUCode[2:0], Reg_CE, CY_CE, A_CE, ResetCY}
  function automatic logic [10:0] rom_word(input logic [4:0] k);
    case (k)
      5'd0:    rom_word = 11'b0000_000_0101;
      5'd1:    rom_word = 11'b0001_001_0010;
      5'd2:    rom_word = 11'b0010_010_1000;
      5'd3:    rom_word = 11'b0100_011_0110;
      5'd4:    rom_word = 11'b1000_100_1000;
      5'd5:    rom_word = 11'b0001_101_1000;
      5'd6:    rom_word = 11'b0010_110_0010;
      5'd7:    rom_word = 11'b0100_111_1100;
      5'd8:    rom_word = 11'b1000_001_0010;
      5'd9:    rom_word = 11'b0001_010_1000;
      5'd10:   rom_word = 11'b0010_011_0110;
      5'd11:   rom_word = 11'b0100_100_1000;
      5'd12:   rom_word = 11'b1000_101_0011;
      default: rom_word = 11'b0;
    endcase
  endfunction

  always_comb {a_rom_ra, a_rom_alu, a_rom_rce, a_rom_cce, a_rom_ace, a_rom_rcy} = rom_word(a_addr);
  always_comb {b_rom_ra, b_rom_alu, b_rom_rce, b_rom_cce, b_rom_ace, b_rom_rcy} = rom_word(b_addr);
  assign a_ctrl = {a_ra, a_alu, a_rce, a_cce, a_ace, a_rcy};
  assign b_ctrl = {b_ra, b_alu, b_rce, b_cce, b_ace, b_rcy};

  pp_sequencer #(.ADDR_W(5), .END_ADDR(12)) u_a (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .step_mode(step_mode), .step(step),
    .addr(a_addr), .rom_RegAddr(a_rom_ra), .rom_ALUCode(a_rom_alu), .rom_Reg_CE(a_rom_rce),
    .rom_CY_CE(a_rom_cce), .rom_A_CE(a_rom_ace), .rom_ResetCY(a_rom_rcy),
    .RegAddr(a_ra), .ALUCode(a_alu), .Reg_CE(a_rce), .CY_CE(a_cce), .A_CE(a_ace),
    .ResetCY(a_rcy), .busy(a_busy), .done(a_done)
  );

  pp_sequencer #(.ADDR_W(5), .END_ADDR(0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .halt(b_halt), .step_mode(b_step_mode), .step(b_step),
    .addr(b_addr), .rom_RegAddr(b_rom_ra), .rom_ALUCode(b_rom_alu), .rom_Reg_CE(b_rom_rce),
    .rom_CY_CE(b_rom_cce), .rom_A_CE(b_rom_ace), .rom_ResetCY(b_rom_rcy),
    .RegAddr(b_ra), .ALUCode(b_alu), .Reg_CE(b_rce), .CY_CE(b_cce), .A_CE(b_ace),
    .ResetCY(b_rcy), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which the datapath sees any enable from instance A.
  always @(negedge clk) if (a_ctrl[3:0] != 4'b0) en_cnt <= en_cnt + 1;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects instance A in RUN at addr=from with no halt; ends in IDLE right after DONE.
  task automatic issue_seq(input int from);
    for (int k = from; k <= 12; k++) begin
      chk("run_addr", 32'(a_addr), 32'(k));
      chk("run_busy", 32'(a_busy), 32'd1);
      cyc;
      chk("run_ctrl", 32'(a_ctrl), 32'(rom_word(5'(k))));
    end
    chk("done_state_busy", 32'(a_busy), 32'd0);
    chk("done_state_done", 32'(a_done), 32'd0);
    chk("done_state_addr", 32'(a_addr), 32'd12);
    cyc;
    chk("done_pulse", 32'(a_done), 32'd1);
    chk("idle_addr", 32'(a_addr), 32'd0);
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_en", 32'(a_ctrl[3:0]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; step_mode = 1'b0; step = 1'b0;
    b_start = 1'b0; b_halt = 1'b0; b_step_mode = 1'b0; b_step = 1'b0;
    cyc; cyc;
    rst = 1'b0;
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_ctrl", 32'(a_ctrl), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_b_ctrl", 32'(b_ctrl), 32'd0);

    // 1: free run of 13 steps
    en0 = en_cnt;
    start = 1'b1; cyc; start = 1'b0;
    chk("t1_first_ctrl", 32'(a_ctrl), 32'd0);
    for (int k = 0; k <= 5; k++) begin
      chk("t1_addr", 32'(a_addr), 32'(k));
      cyc;
      if (k == 0) chk("t1_step0_resetcy", 32'(a_rcy), 32'd1);
    end
    chk("t1_step5_regaddr", 32'(a_ra), 32'b0001);
    chk("t1_step5_reg_ce", 32'(a_rce), 32'd1);
    chk("t1_step5_a_ce", 32'(a_ace), 32'd0);
    issue_seq(6);
    chk("t1_en_cycles", 32'(en_cnt - en0), 32'd13);
    cyc;
    chk("t1_done_clear", 32'(a_done), 32'd0);

    // 2: halt at addr 4 for three cycles, then resume
    en0 = en_cnt;
    start = 1'b1; cyc; start = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      chk("t2_addr", 32'(a_addr), 32'(k));
      cyc;
      chk("t2_ctrl", 32'(a_ctrl), 32'(rom_word(5'(k))));
    end
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t2_pause_addr", 32'(a_addr), 32'd4);
      chk("t2_pause_en", 32'(a_ctrl[3:0]), 32'd0);
      chk("t2_pause_busy", 32'(a_busy), 32'd1);
    end
    halt = 1'b0; start = 1'b1; cyc; start = 1'b0;
    chk("t2_resume_en", 32'(a_ctrl[3:0]), 32'd0);
    issue_seq(4);
    chk("t2_en_cycles", 32'(en_cnt - en0), 32'd13);
    cyc;

    // 3: single-step with a pulse every third cycle
    en0 = en_cnt;
    step_mode = 1'b1;
    start = 1'b1; cyc; start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        cyc;
        chk("t3_bubble_addr", 32'(a_addr), 32'(k));
        chk("t3_bubble_en", 32'(a_ctrl[3:0]), 32'd0);
      end
      step = 1'b1; cyc; step = 1'b0;
      chk("t3_step_ctrl", 32'(a_ctrl), 32'(rom_word(5'(k))));
    end
    cyc;
    chk("t3_done", 32'(a_done), 32'd1);
    chk("t3_idle_busy", 32'(a_busy), 32'd0);
    chk("t3_en_cycles", 32'(en_cnt - en0), 32'd13);
    step_mode = 1'b0;
    cyc;

    // 4: reset mid-program at addr 7
    start = 1'b1; cyc; start = 1'b0;
    for (int k = 0; k < 7; k++) cyc;
    chk("t4_at7", 32'(a_addr), 32'd7);
    rst = 1'b1; cyc; rst = 1'b0;
    chk("t4_addr", 32'(a_addr), 32'd0);
    chk("t4_ctrl", 32'(a_ctrl), 32'd0);
    chk("t4_busy", 32'(a_busy), 32'd0);
    chk("t4_done", 32'(a_done), 32'd0);
    cyc;
    chk("t4_still_idle", 32'(a_busy), 32'd0);
    chk("t4_still_ctrl", 32'(a_ctrl), 32'd0);
    start = 1'b1; cyc; start = 1'b0;
    issue_seq(0);
    cyc;

    // 5: start+halt in IDLE, start held through RUN and DONE, halt+step in step mode
    start = 1'b1; halt = 1'b1; cyc;
    chk("t5_sh_busy", 32'(a_busy), 32'd0);
    cyc;
    chk("t5_sh_busy2", 32'(a_busy), 32'd0);
    halt = 1'b0;
    cyc;
    issue_seq(0);
    start = 1'b0; cyc;
    chk("t5_after_busy", 32'(a_busy), 32'd0);
    chk("t5_after_addr", 32'(a_addr), 32'd0);
    step_mode = 1'b1;
    start = 1'b1; cyc; start = 1'b0;
    chk("t5_run_busy", 32'(a_busy), 32'd1);
    step = 1'b1; halt = 1'b1; cyc; halt = 1'b0;
    chk("t5_hs_addr", 32'(a_addr), 32'd0);
    chk("t5_hs_en", 32'(a_ctrl[3:0]), 32'd0);
    chk("t5_hs_busy", 32'(a_busy), 32'd1);
    cyc; step = 1'b0;
    chk("t5_pause_step_addr", 32'(a_addr), 32'd0);
    chk("t5_pause_step_en", 32'(a_ctrl[3:0]), 32'd0);
    start = 1'b1; cyc; start = 1'b0;
    step = 1'b1; cyc; step = 1'b0;
    chk("t5_resume_ctrl", 32'(a_ctrl), 32'(rom_word(5'd0)));
    chk("t5_resume_addr", 32'(a_addr), 32'd1);
    rst = 1'b1; cyc; rst = 1'b0;
    step_mode = 1'b0;
    chk("t5_rst_busy", 32'(a_busy), 32'd0);

    // 6: END_ADDR = 0 instance
    b_start = 1'b1; cyc; b_start = 1'b0;
    chk("t6_run_busy", 32'(b_busy), 32'd1);
    chk("t6_run_addr", 32'(b_addr), 32'd0);
    cyc;
    chk("t6_ctrl", 32'(b_ctrl), 32'(rom_word(5'd0)));
    chk("t6_done_state_busy", 32'(b_busy), 32'd0);
    chk("t6_done_state_done", 32'(b_done), 32'd0);
    cyc;
    chk("t6_done", 32'(b_done), 32'd1);
    chk("t6_idle_addr", 32'(b_addr), 32'd0);
    chk("t6_idle_en", 32'(b_ctrl[3:0]), 32'd0);
    cyc;
    chk("t6_done_clear", 32'(b_done), 32'd0);
    chk("t6_idle_busy", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
